// File: rtl/ssd_scan_pkg.sv
// Shared constants for the four-digit seven-segment scanner.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
package ssd_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low digit enables, one per display position.
  localparam logic [3:0] DIG_EN_C3 = 4'b1110;
  localparam logic [3:0] DIG_EN_C2 = 4'b1101;
  localparam logic [3:0] DIG_EN_C1 = 4'b1011;
  localparam logic [3:0] DIG_EN_C0 = 4'b0111;
  localparam logic [3:0] DIG_OFF   = 4'b1111;

  localparam logic [7:0] SSD_DARK  = 8'b11111111;

endpackage

// File: rtl/ssd_scan_bcd2seg.sv
// Combinational BCD to active-low seven-segment decode.
// Codes 10..15 are not digits and render blank.
module bcd2seg
  import ssd_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan.sv
// Time-multiplexed driver for a four-digit mm.ss countdown display,
// with leading-zero blanking and a blink when the count reaches zero.
module ssd_scan
  import ssd_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 16,
  parameter int BLINK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] c0,
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  input  logic       en,
  output logic [3:0] ssd_ctl,
  output logic [7:0] ssd
);

  localparam logic [SCAN_DIV-1:0]  SCAN_ONE  = 1;
  localparam logic [BLINK_DIV-1:0] BLINK_ONE = 1;

  logic [SCAN_DIV-1:0]  refresh_cnt;
  logic [BLINK_DIV-1:0] blink_cnt;
  logic [1:0]           idx;
  logic                 wrap;
  logic [3:0]           digit;
  logic [3:0]           ctl_next;
  logic [6:0]           seg_dec;
  logic [6:0]           seg_lit;
  logic                 dp;
  logic                 lead_blank;
  logic                 zero_state;
  logic                 blink_on;
  logic                 blink_dark;
  logic [7:0]           ssd_next;

  assign wrap = &refresh_cnt;

  always_comb begin
    digit    = c3;
    ctl_next = DIG_EN_C3;
    case (idx)
      2'd0: begin digit = c3; ctl_next = DIG_EN_C3; end
      2'd1: begin digit = c2; ctl_next = DIG_EN_C2; end
      2'd2: begin digit = c1; ctl_next = DIG_EN_C1; end
      2'd3: begin digit = c0; ctl_next = DIG_EN_C0; end
      default: begin digit = c3; ctl_next = DIG_EN_C3; end
    endcase
  end

  bcd2seg u_bcd2seg (
    .bcd (digit),
    .seg (seg_dec)
  );

  assign lead_blank = (idx == 2'd3) && (c0 == 4'd0);
  assign seg_lit    = lead_blank ? SEG_BLANK : seg_dec;
  assign dp         = (idx == 2'd2) ? 1'b0 : 1'b1;

  assign zero_state = (c0 == 4'd0) && (c1 == 4'd0) && (c2 == 4'd0) && (c3 == 4'd0);
  assign blink_on   = zero_state && en;
  // Gate with blink_on so a stale count cannot darken a slot once blinking stops.
  assign blink_dark = blink_on && blink_cnt[BLINK_DIV-1];
  assign ssd_next   = blink_dark ? SSD_DARK : {seg_lit, dp};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      idx         <= 2'd0;
      ssd_ctl     <= DIG_OFF;
      ssd         <= SSD_DARK;
    end else begin
      refresh_cnt <= refresh_cnt + SCAN_ONE;
      blink_cnt   <= blink_on ? (blink_cnt + BLINK_ONE) : '0;
      // Enable and segments load together so a digit never shows another's pattern.
      if (wrap) begin
        ssd_ctl <= ctl_next;
        ssd     <= ssd_next;
        idx     <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan with short dividers (SCAN_DIV=2, BLINK_DIV=4).
// Expected patterns are hand-computed from the segment table.
module tb_ssd_scan;

  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] c0, c1, c2, c3;
  logic       en;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd;

  int n_cmp = 0;
  int n_mis = 0;
  int slot  = 0;

  localparam logic [3:0] CTL_TBL   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // digits 1,2,3,4 -> positions c3..c0 show 4,3,2.,1
  localparam logic [7:0] SCAN_TBL  [4] = '{8'b10011001, 8'b00001101, 8'b00100100, 8'b10011111};
  // digits 0,5,9,12 -> c3 blank(12), c2 9, c1 5., c0 leading-zero blank
  localparam logic [7:0] BLANK_TBL [4] = '{8'b11111111, 8'b00001001, 8'b01001000, 8'b11111111};
  // all zero -> c3 0, c2 0, c1 0., c0 leading-zero blank
  localparam logic [7:0] ZERO_TBL  [4] = '{8'b00000011, 8'b00000011, 8'b00000010, 8'b11111111};

  always #5 clk = ~clk;

  ssd_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c0      (c0),
    .c1      (c1),
    .c2      (c2),
    .c3      (c3),
    .en      (en),
    .ssd_ctl (ssd_ctl),
    .ssd     (ssd)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_slot(input string tag, input logic [7:0] exp_ssd);
    check_val({tag, "_ctl"}, {4'b0000, ssd_ctl}, {4'b0000, CTL_TBL[slot]});
    check_val({tag, "_ssd"}, ssd, exp_ssd);
  endtask

  // Check at slot start and mid-slot, then land on the next slot's first negedge.
  task automatic hold_slot(input string tag, input logic [7:0] exp_ssd);
    check_slot(tag, exp_ssd);
    repeat (2) @(negedge clk);
    check_slot({tag, "_mid"}, exp_ssd);
    repeat (2) @(negedge clk);
    slot = (slot + 1) % 4;
  endtask

  task automatic next_slot;
    repeat (4) @(negedge clk);
    slot = (slot + 1) % 4;
  endtask

  task automatic set_digits(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    c0 = d0; c1 = d1; c2 = d2; c3 = d3;
  endtask

  // Release reset on a negedge; the 4th rising edge after it is the first wrap.
  task automatic release_and_sync;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("pre_wrap_ctl", {4'b0000, ssd_ctl}, 8'h0f);
    @(negedge clk);
    slot = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) @(negedge clk);
    check_val("rst_ctl", {4'b0000, ssd_ctl}, 8'h0f);
    check_val("rst_ssd", ssd, 8'hff);

    release_and_sync();
    for (int i = 0; i < 8; i++) hold_slot("scan", SCAN_TBL[slot]);

    set_digits(4'd0, 4'd5, 4'd9, 4'd12);
    for (int i = 0; i < 4; i++) begin
      next_slot();
      check_slot("blank", BLANK_TBL[slot]);
    end

    // c2 changes in the middle of its own slot
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    next_slot();
    check_slot("c2_old", SCAN_TBL[1]);
    repeat (2) @(negedge clk);
    c2 = 4'd7;
    @(negedge clk);
    check_slot("c2_hold", SCAN_TBL[1]);
    @(negedge clk);
    slot = 2;
    for (int i = 0; i < 3; i++) begin
      check_slot("after_chg", SCAN_TBL[slot]);
      next_slot();
    end
    check_slot("c2_new", 8'b00011111);

    // asynchronous reset during index 2
    next_slot();
    check_slot("pre_arst", SCAN_TBL[2]);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_ctl", {4'b0000, ssd_ctl}, 8'h0f);
    check_val("arst_ssd", ssd, 8'hff);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check_val("arst_hold_ssd", ssd, 8'hff);

    // blink: 2 visible slots, 2 dark slots, alternating
    release_and_sync();
    for (int k = 0; k < 8; k++)
      hold_slot("blink", ((k % 4) >= 2) ? 8'hff : ZERO_TBL[slot]);

    en = 1'b0;
    for (int k = 0; k < 8; k++) hold_slot("steady", ZERO_TBL[slot]);

    // re-enable: counter restarts from 0, so the episode opens visible
    en = 1'b1;
    for (int k = 0; k < 6; k++)
      hold_slot("reblink", (k == 3 || k == 4) ? 8'hff : ZERO_TBL[slot]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter SCAN_DIV, default 16: width of the refresh divider; the digit advances every 2^SCAN_DIV clk cycles.
REQ-002 Parameter BLINK_DIV, default 25: width of the blink divider; the blink phase toggles every 2^(BLINK_DIV-1) clk cycles.
REQ-003 clk  input  1  board clock; the single clock of the block.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 c0  input  4  BCD minute tens, leftmost digit.
REQ-006 c1  input  4  BCD minute units.
REQ-007 c2  input  4  BCD second tens.
REQ-008 c3  input  4  BCD second units, rightmost digit.
REQ-009 en  input  1  countdown running flag from the counter stage.
REQ-010 ssd_ctl  output  4  active-low digit enables; bit3 = c0 position, bit0 = c3 position.
REQ-011 ssd  output  8  active-low segments {a,b,c,d,e,f,g,dp}.

Function
REQ-012 Refresh divider: free-running SCAN_DIV-bit up-counter; on wrap from all-ones to 0, the 2-bit digit index increments modulo 4.
REQ-013 Digit index mapping: 0 -> c3 with ssd_ctl=1110; 1 -> c2 with 1101; 2 -> c1 with 1011; 3 -> c0 with 0111.
REQ-014 ssd_ctl and ssd are registered, and both update in the same clk edge as the index, so a digit enable and its segments are always coherent.
REQ-015 Segment decode for 0..9 uses the standard active-low patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100 (bits a..g).
REQ-016 BCD inputs 10..15 are decoded as blank (a..g = 1111111).
REQ-017 The decimal point (dp=0) is lit only on the c1 position (minutes.seconds separator); elsewhere dp=1.
REQ-018 Leading-zero blanking: the c0 position is blank (a..g = 1111111) when c0==0; dp rules still apply.
REQ-019 Zero state: c0..c3 all 0.
REQ-020 Blink: while the zero state and en=1 both hold, a BLINK_DIV-bit counter runs; when its MSB=1 all four positions output ssd=11111111 (ssd_ctl keeps scanning).
REQ-021 The blink counter is held at 0 whenever the blink condition is false, so every blink episode starts with the visible phase.
REQ-022 With en=0, the display is steady (no blink) regardless of the digit values.
REQ-023 Inputs are sampled at the update edge of the position being driven; a change mid-slot appears at that position's next slot.
REQ-024 No handshake: the block is purely a consumer and never stalls the counter stage.

Reset
REQ-025 While reset_n=0, the refresh counter, blink counter and digit index are 0, ssd_ctl=1111 and ssd=11111111 (display dark).
REQ-026 On the first refresh wrap after reset release, index 0 (c3 position) is driven; assertion of reset mid-scan blanks the outputs immediately (asynchronous).

Structure
REQ-027 A shared package holds the ten segment-pattern constants, the BLANK pattern, and the four digit-enable constants.
REQ-028 One sub-module, bcd2seg (combinational 4-bit BCD to 7-bit active-low decode including the 10..15 blank rule), is instantiated once on the muxed digit.

Verification (SCAN_DIV=2, BLINK_DIV=4 in simulation)
REQ-029 Reset: hold reset_n=0 -> ssd_ctl=1111, ssd=11111111; release it -> after 4 clk cycles ssd_ctl=1110.
REQ-030 Scan: c0..c3=1,2,3,4 with en=1 -> the sequence (1110,ssd=1001100_1), (1101,0000110_1), (1011,0010010_0), (0111,1001111_1), then it repeats every 16 cycles.
REQ-031 Blanking: c0..c3=0,5,9,12 -> the c0 position is blank, c1 shows 5 with dp=0, c2 shows 9, and c3 is blank (value 12).
REQ-032 Blink: all digits 0 with en=1 -> the visible phase lasts 8 cycles, then all ssd=11111111 for 8 cycles, alternating; dropping en to 0 gives a steady display with the blink counter cleared.
REQ-033 Mid-slot change: change c2 during the c2 slot -> the old value is held until the next c2 slot.
REQ-034 Reset mid-scan: assert reset_n=0 during index 2 -> the outputs go dark without waiting for clk; after release, scanning restarts at index 0.
